// File: rtl/frame_reader_pkg.sv
// rtl/frame_reader_pkg.sv - shared types and field widths for the frame reader
//
// Purpose: FSM state encoding, DRAM address field widths and pixel width
// used by frame_reader and its pixel FIFO.
package frame_reader_pkg;

  typedef enum logic [1:0] {
    LATCH      = 2'd0,
    WAIT_SPACE = 2'd1,
    REQ        = 2'd2,
    RECV       = 2'd3
  } state_t;

  // req_addr = {base[31:BASE_LSB], y[Y_W-1:0], x[X_W-1:0], 2'b00}
  localparam int X_W      = 10;
  localparam int Y_W      = 10;
  localparam int BASE_LSB = 22;
  localparam int PIX_W    = 24;

endpackage

// File: rtl/pixel_fifo.sv
// rtl/pixel_fifo.sv - synchronous pixel FIFO with free-entry count
//
// Purpose: buffers returned read data between the fetch FSM and the video
// output. Head data is read combinationally (zero added latency on pop side).
// Ports:
//   clk, resetn          clock, synchronous active-low reset (empties FIFO)
//   push, push_data      write one entry (ignored when full)
//   pop                  remove head entry (ignored when empty)
//   head                 current head entry
//   full, empty          occupancy flags
//   free                 number of free entries (0..DEPTH)
module pixel_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     free
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible once counted.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
  assign free  = (AW+1)'(DEPTH) - count;

endmodule

// File: rtl/frame_reader.sv
// rtl/frame_reader.sv - frame buffer read engine streaming pixels to video out
//
// Purpose: fetches a frame from DRAM in raster order as BURST-word reads,
// buffers words in pixel_fifo and presents one pixel per accepted beat.
// Ports:
//   clk, resetn                       clock, synchronous active-low reset
//   frame_base                        frame base, captured at frame start
//   req_valid/req_ready/req_addr      burst read request channel
//   resp_valid/resp_data              read data beats, pixel in [23:0]
//   video_valid/video_ready           pixel stream handshake
//   video_pixel, video_eof            pixel and last-pixel-of-frame marker
//   underflow_count                   starved-sink cycle counter
// Build option: FRAME_READER_UNDERFLOW_EN enables underflow_count; when
// undefined the output is tied to zero.
module frame_reader
  import frame_reader_pkg::*;
#(
  parameter int H_PIXELS   = 800,
  parameter int V_LINES    = 600,
  parameter int BURST      = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [31:0]      frame_base,
  output logic             req_valid,
  input  logic             req_ready,
  output logic [31:0]      req_addr,
  input  logic             resp_valid,
  input  logic [31:0]      resp_data,
  output logic             video_valid,
  input  logic             video_ready,
  output logic [PIX_W-1:0] video_pixel,
  output logic             video_eof,
  output logic [15:0]      underflow_count
);

  localparam int FW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;

  localparam logic [X_W:0]   X_STEP    = (X_W+1)'(BURST);
  localparam logic [X_W:0]   X_END     = (X_W+1)'(H_PIXELS);
  localparam logic [X_W-1:0] X_LAST    = X_W'(H_PIXELS - 1);
  localparam logic [Y_W-1:0] Y_LAST    = Y_W'(V_LINES - 1);
  localparam logic [BW-1:0]  BEAT_LAST = BW'(BURST - 1);
  localparam logic [FW-1:0]  FREE_MIN  = FW'(BURST);

  state_t              state_q, state_d;
  logic [31:BASE_LSB]  base_q;
  logic [X_W-1:0]      x_q;
  logic [Y_W-1:0]      y_q;
  logic [BW-1:0]       beat_q;
  logic [X_W-1:0]      ox_q;
  logic [Y_W-1:0]      oy_q;

  logic                fifo_push;
  logic                fifo_pop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [FW-1:0]       fifo_free;
  logic [PIX_W-1:0]    fifo_head;

  logic                x_wrap;
  logic                last_beat;
  logic                unused_bits;

  assign unused_bits = ^{resp_data[31:PIX_W], frame_base[BASE_LSB-1:0]};

  // Beats outside RECV are dropped; the full gate never fires thanks to the
  // free-space check before each request.
  assign fifo_push = (state_q == RECV) && resp_valid && !fifo_full;
  assign x_wrap    = (({1'b0, x_q} + X_STEP) == X_END);
  assign last_beat = fifo_push && (beat_q == BEAT_LAST);

  pixel_fifo #(
    .WIDTH (PIX_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (fifo_push),
    .push_data (resp_data[PIX_W-1:0]),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .free      (fifo_free)
  );

  always_comb begin
    state_d   = state_q;
    req_valid = 1'b0;
    case (state_q)
      LATCH:      state_d = WAIT_SPACE;
      WAIT_SPACE: if (fifo_free >= FREE_MIN) state_d = REQ;
      REQ: begin
        req_valid = 1'b1;
        if (req_ready) state_d = RECV;
      end
      RECV: begin
        if (last_beat) state_d = (x_wrap && (y_q == Y_LAST)) ? LATCH : WAIT_SPACE;
      end
      default:    state_d = LATCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= LATCH;
      base_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        LATCH: begin
          base_q <= frame_base[31:BASE_LSB];
          x_q    <= '0;
          y_q    <= '0;
        end
        REQ: begin
          if (req_ready) beat_q <= '0;
        end
        RECV: begin
          if (fifo_push) begin
            beat_q <= beat_q + BW'(1);
            if (beat_q == BEAT_LAST) begin
              if (x_wrap) begin
                x_q <= '0;
                // On the final line LATCH re-zeroes y, so leave it alone.
                if (y_q != Y_LAST) y_q <= y_q + Y_W'(1);
              end else begin
                x_q <= x_q + X_W'(BURST);
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign req_addr = {base_q, y_q, x_q, 2'b00};

  assign video_valid = !fifo_empty;
  assign video_pixel = fifo_head;
  assign fifo_pop    = video_valid && video_ready;
  assign video_eof   = video_valid && (ox_q == X_LAST) && (oy_q == Y_LAST);

  // Output-side raster position, advanced per popped pixel.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ox_q <= '0;
      oy_q <= '0;
    end else if (fifo_pop) begin
      if (ox_q == X_LAST) begin
        ox_q <= '0;
        oy_q <= (oy_q == Y_LAST) ? '0 : oy_q + Y_W'(1);
      end else begin
        ox_q <= ox_q + X_W'(1);
      end
    end
  end

`ifdef FRAME_READER_UNDERFLOW_EN
  logic [15:0] underflow_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      underflow_q <= '0;
    end else if (video_ready && fifo_empty && (state_q != LATCH) &&
                 (underflow_q != 16'hFFFF)) begin
      underflow_q <= underflow_q + 16'd1;
    end
  end

  assign underflow_count = underflow_q;
`else
  assign underflow_count = 16'h0000;
`endif

endmodule

// File: tb/tb_frame_reader.sv
// tb/tb_frame_reader.sv - scoreboard bench for frame_reader
module tb_frame_reader;

  localparam int H = 16;
  localparam int V = 2;
  localparam int B = 8;
  localparam int D = 16;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] frame_base = 32'h1080_0000;
  logic        req_valid;
  logic        req_ready = 1'b0;
  logic [31:0] req_addr;
  logic        resp_valid = 1'b0;
  logic [31:0] resp_data = 32'h0;
  logic        video_valid;
  logic        video_ready = 1'b0;
  logic [23:0] video_pixel;
  logic        video_eof;
  logic [15:0] underflow_count;

  frame_reader #(
    .H_PIXELS   (H),
    .V_LINES    (V),
    .BURST      (B),
    .FIFO_DEPTH (D)
  ) dut (
    .clk             (clk),
    .resetn          (resetn),
    .frame_base      (frame_base),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_addr        (req_addr),
    .resp_valid      (resp_valid),
    .resp_data       (resp_data),
    .video_valid     (video_valid),
    .video_ready     (video_ready),
    .video_pixel     (video_pixel),
    .video_eof       (video_eof),
    .underflow_count (underflow_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int req_accepted = 0;
  int pix_popped = 0;
  int burst_beats = 0;
  int mem_delay = 0;
  bit stray_req = 1'b0;

  logic [31:0] exp_req[$];
  logic [24:0] exp_pix[$];

  task automatic check(input bit ok, input string name,
                       input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  // Expected requests and pixels for one frame; memory returns word address.
  task automatic push_frame(input logic [31:0] base);
    logic [31:0] b;
    logic [31:0] w;
    b = base & 32'hFFC0_0000;
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x += B)
        exp_req.push_back(b + 32'(y * 4096) + 32'(x * 4));
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++) begin
        w = (b >> 2) + 32'(y * 1024) + 32'(x);
        exp_pix.push_back({(y == V - 1) && (x == H - 1), w[23:0]});
      end
  endtask

  // Memory model: one burst per accepted request, beats from the next cycle.
  initial begin
    logic [31:0] a;
    bit aborted;
    forever begin
      @(negedge clk);
      if (stray_req) begin
        @(posedge clk); #1;
        resp_valid = 1'b1;
        resp_data  = 32'hDEAD_BEEF;
        repeat (2) begin @(posedge clk); #1; end
        resp_valid = 1'b0;
        stray_req  = 1'b0;
      end else if (resetn && req_valid && req_ready) begin
        a = req_addr;
        burst_beats = 0;
        aborted = 1'b0;
        @(posedge clk); #1;
        for (int d = 0; d < mem_delay; d++) begin @(posedge clk); #1; end
        for (int i = 0; i < B; i++) begin
          resp_valid = 1'b1;
          resp_data  = (a >> 2) + 32'(i);
          @(posedge clk);
          if (!resetn) begin
            aborted = 1'b1;
            break;
          end
          burst_beats++;
          #1;
        end
        if (aborted) #1;
        resp_valid = 1'b0;
      end
    end
  end

  // Request monitor: order/address of acceptances and stability while stalled.
  initial begin
    logic        prev_stall;
    logic [31:0] prev_addr;
    logic [31:0] e;
    prev_stall = 1'b0;
    prev_addr  = 32'h0;
    forever begin
      @(negedge clk);
      if (resetn && prev_stall)
        check(req_valid === 1'b1 && req_addr === prev_addr, "req_hold", req_addr, prev_addr);
      prev_stall = resetn && req_valid && !req_ready;
      prev_addr  = req_addr;
      if (resetn && req_valid && req_ready) begin
        req_accepted++;
        if (exp_req.size() == 0) begin
          check(1'b0, "req_unexpected", req_addr, 32'h0);
        end else begin
          e = exp_req.pop_front();
          check(req_addr === e, "req_addr", req_addr, e);
        end
      end
    end
  end

  // Pixel monitor: every popped pixel against the scoreboard.
  initial begin
    logic [24:0] e;
    forever begin
      @(negedge clk);
      if (resetn && video_valid && video_ready) begin
        pix_popped++;
        if (exp_pix.size() == 0) begin
          check(1'b0, "pix_unexpected", {8'h0, video_pixel}, 32'h0);
        end else begin
          e = exp_pix.pop_front();
          check(video_pixel === e[23:0], "pixel", {8'h0, video_pixel}, {8'h0, e[23:0]});
          check(video_eof === e[24], "eof", {31'h0, video_eof}, {31'h0, e[24]});
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int n;
    int p0;
    logic [15:0] uc0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check(req_valid === 1'b0, "rst_req_valid", {31'h0, req_valid}, 32'h0);
    check(req_addr === 32'h0, "rst_req_addr", req_addr, 32'h0);
    check(video_valid === 1'b0, "rst_video_valid", {31'h0, video_valid}, 32'h0);
    check(video_eof === 1'b0, "rst_video_eof", {31'h0, video_eof}, 32'h0);
    check(underflow_count === 16'h0, "rst_underflow", {16'h0, underflow_count}, 32'h0);

    // Frames 1-2 at 108xxxxx, frames 3-4 at 20000000.
    push_frame(32'h1080_0000);
    push_frame(32'h1080_0000);
    push_frame(32'h2000_0000);
    push_frame(32'h2000_0000);

    @(posedge clk); #1;
    resetn = 1'b1;
    req_ready = 1'b1;
    video_ready = 1'b1;

    for (n = 0; n < 600 && req_accepted < 5; n++) begin @(posedge clk); #1; end
    check(req_accepted >= 5, "wait_frame2", req_accepted, 5);

    // Base change mid-frame 2 and request stall.
    frame_base = 32'h2000_0000;
    req_ready = 1'b0;
    for (n = 0; n < 60 && !req_valid; n++) begin @(posedge clk); #1; end
    check(req_valid === 1'b1, "stall_req_seen", {31'h0, req_valid}, 32'h1);
    repeat (5) begin @(posedge clk); #1; end
    req_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    check(req_accepted == 6, "stall_one_accept", req_accepted, 6);

    // Back-pressure from the start of frame 3.
    for (n = 0; n < 600 && req_accepted < 9; n++) begin @(posedge clk); #1; end
    check(req_accepted >= 9, "wait_frame3", req_accepted, 9);
    video_ready = 1'b0;
    repeat (40) begin @(posedge clk); #1; end
    check(req_accepted == 10, "bp_two_bursts", req_accepted, 10);
    check(req_valid === 1'b0, "bp_req_idle", {31'h0, req_valid}, 32'h0);
    check(video_valid === 1'b1, "bp_fifo_full", {31'h0, video_valid}, 32'h1);
    stray_req = 1'b1;
    repeat (6) begin @(posedge clk); #1; end
    check(req_valid === 1'b0 && req_accepted == 10, "stray_ignored", req_accepted, 10);
    p0 = pix_popped;
    video_ready = 1'b1;
    for (n = 0; n < 40 && !req_valid; n++) begin @(posedge clk); #1; end
    check(pix_popped - p0 >= 8 && pix_popped - p0 <= 9, "bp_pops_before_req", pix_popped - p0, 8);

    // Reset after the third beat of frame 4's first burst.
    for (n = 0; n < 800 && !(req_accepted >= 13 && burst_beats == 3); n++) begin
      @(posedge clk); #2;
    end
    check(req_accepted >= 13 && burst_beats == 3, "wait_recv3", burst_beats, 3);
    resetn = 1'b0;
    exp_req.delete();
    exp_pix.delete();
    push_frame(32'h2000_0000);
    @(posedge clk); #2;
    check(video_valid === 1'b0, "mid_rst_video_valid", {31'h0, video_valid}, 32'h0);
    check(req_valid === 1'b0, "mid_rst_req_valid", {31'h0, req_valid}, 32'h0);
    check(video_eof === 1'b0, "mid_rst_eof", {31'h0, video_eof}, 32'h0);
    resetn = 1'b1;

    for (n = 0; n < 600 && exp_req.size() != 0; n++) begin @(posedge clk); #1; end
    req_ready = 1'b0;
    for (n = 0; n < 200 && exp_pix.size() != 0; n++) begin @(posedge clk); #1; end
    check(exp_req.size() == 0 && exp_pix.size() == 0, "fresh_frame_done",
          exp_pix.size(), 0);

    // Slow memory with a hungry sink.
    uc0 = underflow_count;
    push_frame(32'h2000_0000);
    mem_delay = 10;
    req_ready = 1'b1;
    for (n = 0; n < 1000 && exp_req.size() != 0; n++) begin @(posedge clk); #1; end
    req_ready = 1'b0;
    for (n = 0; n < 200 && exp_pix.size() != 0; n++) begin @(posedge clk); #1; end
    repeat (5) begin @(posedge clk); #1; end
    check(exp_req.size() == 0 && exp_pix.size() == 0, "slow_frame_done",
          exp_pix.size(), 0);
`ifdef FRAME_READER_UNDERFLOW_EN
    check((underflow_count - uc0) >= 16'd10, "underflow_count",
          {16'h0, underflow_count - uc0}, 32'd10);
`else
    check(underflow_count === 16'h0 && uc0 === 16'h0, "underflow_tied",
          {16'h0, underflow_count}, 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/frame_reader.md
Name: frame_reader

Overview:
- Read side of the frame buffer. Streams pixels that the line and fill engines wrote to DRAM back out to the video output, in raster order.
- Issues burst read requests at addresses built from the frame base register, and buffers returned words in a small FIFO.
- Presents one pixel per accepted beat on a valid/ready video interface, with an end-of-frame marker.

Parameters:
- H_PIXELS, 800, pixels per line. Must be a multiple of BURST.
- V_LINES, 600, lines per frame.
- BURST, 8, words (pixels) per read request. Power of 2.
- FIFO_DEPTH, 16, pixel FIFO entries. Power of 2, at least 2*BURST.

Ports:
- Clock  in  1  system clock.
- Reset  in  1  synchronous, active-low reset.
- frame_base  in  32  frame base register; sampled only at frame start.
- req_valid  out  1  read request valid.
- req_ready  in  1  memory accepts request.
- req_addr  out  32  byte address of first word of burst.
- resp_valid  in  1  read data beat valid.
- resp_data  in  32  read data; pixel RGB in [23:0].
- video_valid  out  1  pixel available.
- video_ready  in  1  sink consumes pixel.
- video_pixel  out  24  RGB pixel.
- video_eof  out  1  qualifies the last pixel of a frame.
- underflow_count  out  16  see Optional Feature.

Behaviour:
- Reset (Reset==0 at a Clock edge):
  - FSM goes to LATCH; fetch counters x=y=0; output counters ox=oy=0; FIFO emptied.
  - req_valid=0, req_addr=0, video_valid=0, video_eof=0, underflow_count=0.
- Address: req_addr = {base_q[31:22], y[9:0], x[9:0], 2'b00}.
  - base_q is frame_base captured in LATCH.
  - x steps by BURST; y steps by 1.
- FSM:
  - LATCH: base_q<=frame_base, x<=0, y<=0. Next cycle go to WAIT_SPACE.
  - WAIT_SPACE: when FIFO free entries >= BURST, go to REQ.
  - REQ: req_valid=1, req_addr stable. req_valid stays high and req_addr constant until req_ready; the request is accepted in the cycle where req_valid&&req_ready. Then go to RECV with beat counter=0.
  - RECV: each resp_valid pushes resp_data[23:0] into the FIFO and increments the beat counter. On beat BURST-1:
    - x+BURST==H_PIXELS: x<=0.
    - If also y==V_LINES-1: go to LATCH.
    - Else if x wrapped: y<=y+1, go to WAIT_SPACE.
    - Else: x<=x+BURST, go to WAIT_SPACE.
- Only one burst is outstanding at a time. Because of the credit check, the FIFO never overflows.
- resp_valid outside RECV is ignored; the data is dropped and no state changes.
- Video side:
  - video_valid = FIFO not empty; video_pixel = FIFO head. Combinational from FIFO state, with zero added latency.
  - A pop happens on video_valid&&video_ready.
  - ox/oy track popped pixels and wrap the same way as x/y.
  - video_eof = video_valid && ox==H_PIXELS-1 && oy==V_LINES-1.
- FIFO:
  - Push and pop in the same cycle leaves the count unchanged.
  - Push while full is impossible by construction. Pop while empty is prevented (video_valid=0).
- Latency: first pixel is valid at the earliest 1 cycle after the first response beat (FIFO write then read).
- Reset mid-burst: the FSM aborts immediately. The memory controller shares Reset, so no stale beats arrive afterwards.
- frame_base changes mid-frame have no effect until the next LATCH.

Optional Feature:
- Macro: FRAME_READER_UNDERFLOW_EN.
- Defined: underflow_count increments each cycle that video_ready==1 && FIFO empty && the state is not LATCH. It saturates at 16'hFFFF and is cleared only by reset.
- Not defined: underflow_count is tied to 0 and no counter logic is built.

Decomposition:
- Package frame_reader_pkg holds:
  - FSM state enum {LATCH, WAIT_SPACE, REQ, RECV}.
  - Address field widths (X_W=10, Y_W=10, BASE_LSB=22).
  - Pixel width PIX_W=24.
- Sub-module pixel_fifo: synchronous FIFO with parameters WIDTH and DEPTH. Outputs: full, empty, free count, head data. Same Clock and Reset.

Test Plan (H_PIXELS=16, V_LINES=2, BURST=8, FIFO_DEPTH=16 unless noted):
- Basic frame: frame_base=32'h10800000, memory with req_ready=1 and returning data=address>>2 one cycle later, video_ready=1.
  - Required: 4 requests at addresses 10800000, 10800020, 10801000, 10801020.
  - Required: 32 pixels in order, with video_eof only on the 32nd.
  - Required: the next request is back at 10800000.
- Request stall: hold req_ready=0 for 5 cycles.
  - Required: req_valid held high with req_addr constant; exactly one acceptance.
- Back-pressure: video_ready=0.
  - Required: exactly 2 bursts (16 pixels) are fetched, then the FSM sits in WAIT_SPACE with req_valid=0.
  - Then raise video_ready: after 8 pops the next request is issued.
- Base change: change frame_base to 32'h20000000 mid-frame.
  - Required: the current frame still uses 108xxxxx; the next frame starts at 20000000.
- Reset mid-RECV: assert Reset for 1 cycle after 3 beats.
  - Required: FIFO empty, video_valid=0, first new request at base, a full fresh frame follows.
- With FRAME_READER_UNDERFLOW_EN: a memory delay of 10 cycles with video_ready=1 gives underflow_count>=10. Without the macro it stays 0.
